// File: rtl/if_fetch_queue_pkg.sv
// if_fetch_queue_pkg: memory map defaults, exception code and the queued fetch entry layout.
package if_fetch_queue_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF = 32'h0000_3000;
    localparam int IM_WORDS_DEF = 4096;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] code;
        logic exc;
    } fetch_entry_t;
endpackage

// File: rtl/if_fetch_queue_fifo.sv
// fetch_fifo: synchronous FIFO with clear; push and pop may coincide even when full.
module fetch_fifo #(
    parameter int W = 32,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic push,
    input  logic pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;
    always_comb begin
        dout = mem[rd_ptr];
        full = count == CW'(DEPTH);
        empty = count == '0;
    end
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch PC owner issuing in-order imem requests and queueing
// returned {pc, code, exc} entries for decode, with redirect flush.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] IM_BASE = IM_BASE_DEF,
    parameter int IM_WORDS = IM_WORDS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic redirect,
    input  logic [31:0] redirect_pc,
    output logic imem_req,
    output logic [31:0] imem_addr,
    input  logic imem_gnt,
    input  logic imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic id_valid,
    input  logic id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_code,
    output logic id_exc,
    output logic [31:0] pc_if,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [32:0] IM_SPAN = 33'(IM_WORDS) << 2;
    logic [CW-1:0] outstanding, discard, side_count;
    logic halted, credit, legal, issue, resp, resp_push, exc_push, push, pop;
    logic entry_empty, entry_full, side_empty, side_full;
    logic [31:0] side_pc;
    fetch_entry_t push_entry, head;
    always_comb begin
        credit = ({1'b0, outstanding} + {1'b0, occupancy}) < DEPTH_C;
        legal = pc_if[1:0] == 2'b00 && pc_if >= IM_BASE && {1'b0, pc_if} < {1'b0, IM_BASE} + IM_SPAN;
        imem_req = credit && !halted && !redirect && legal;
        imem_addr = pc_if;
        issue = imem_req && imem_gnt;
        resp = imem_rvalid && outstanding != '0;
        resp_push = resp && discard == '0 && !redirect;
        // the AdEL entry waits for older responses so queue order follows fetch order
        exc_push = !legal && credit && !halted && !redirect && outstanding == '0;
        push = resp_push || exc_push;
        push_entry = resp_push ? fetch_entry_t'{side_pc, imem_rdata, 1'b0} : fetch_entry_t'{pc_if, 32'h0, 1'b1};
        id_valid = !entry_empty;
        pop = id_valid && id_ready && !redirect;
        id_pc = id_valid ? head.pc : '0;
        id_code = id_valid ? head.code : '0;
        id_exc = id_valid && head.exc;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_if <= RESET_PC;
            outstanding <= '0;
            discard <= '0;
            halted <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(resp);
            if (redirect) begin
                pc_if <= redirect_pc;
                halted <= 1'b0;
                discard <= outstanding - CW'(resp);
            end else begin
                if (issue) pc_if <= pc_if + 32'd4;
                if (exc_push) halted <= 1'b1;
                if (resp && discard != '0) discard <= discard - 1'b1;
            end
        end
    end
    fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_entries (
        .clk(clk), .reset(reset), .clear(redirect), .push(push), .pop(pop),
        .din(push_entry), .dout(head), .full(entry_full), .empty(entry_empty), .count(occupancy)
    );
    // PCs of live requests; discarded responses were flushed from here at redirect
    fetch_fifo #(.W(32), .DEPTH(DEPTH)) u_side (
        .clk(clk), .reset(reset), .clear(redirect), .push(issue), .pop(resp_push),
        .din(pc_if), .dout(side_pc), .full(side_full), .empty(side_empty), .count(side_count)
    );
    assert property (@(posedge clk) disable iff (reset) !(imem_rvalid && outstanding == '0));
    assert property (@(posedge clk) disable iff (reset) !(push && entry_full && !pop));
    assert property (@(posedge clk) disable iff (reset) !(issue && side_full));
    assert property (@(posedge clk) disable iff (reset) !(resp_push && side_empty));
    assert property (@(posedge clk) disable iff (reset) side_count <= outstanding);
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: queue-based reference model compared every cycle, directed scenarios, then random traffic.
module tb_if_fetch_queue;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h3000;
    localparam logic [31:0] IM_BASE = 32'h3000;
    localparam logic [31:0] IM_END = 32'h7000;
    logic clk = 0, reset, redirect, imem_gnt, imem_rvalid, id_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic imem_req, id_valid, id_exc;
    logic [31:0] imem_addr, id_pc, id_code, pc_if;
    logic [2:0] occupancy;
    int n_vec = 0, n_err = 0;
    typedef struct {logic [31:0] pc; logic [31:0] code; logic exc;} ent_t;
    typedef struct {logic [31:0] pc; bit drop;} req_t;
    ent_t mq[$];
    req_t rq[$];
    logic [31:0] m_pc;
    bit m_halt, started = 0;
    if_fetch_queue dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
        .id_ready(id_ready), .id_pc(id_pc), .id_code(id_code), .id_exc(id_exc),
        .pc_if(pc_if), .occupancy(occupancy)
    );
    always #5 clk = ~clk;
    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction
    function automatic bit m_legal(logic [31:0] p);
        return p[1:0] == 2'b00 && p >= IM_BASE && p < IM_END;
    endfunction
    function automatic bit m_credit();
        return rq.size() + mq.size() < DEPTH;
    endfunction
    function automatic bit m_req();
        return m_credit() && !m_halt && !redirect && m_legal(m_pc);
    endfunction
    always @(posedge clk) begin : model
        bit req, pop, exc;
        req_t r;
        if (reset) begin
            mq.delete();
            rq.delete();
            m_pc = RESET_PC;
            m_halt = 0;
            started = 1;
        end else if (started) begin
            req = m_req();
            pop = mq.size() > 0 && id_ready;
            exc = !m_legal(m_pc) && m_credit() && !m_halt && rq.size() == 0;
            if (redirect) begin
                mq.delete();
                if (imem_rvalid && rq.size() > 0) void'(rq.pop_front());
                foreach (rq[i]) rq[i].drop = 1;
                m_pc = redirect_pc;
                m_halt = 0;
            end else begin
                if (pop) void'(mq.pop_front());
                if (imem_rvalid && rq.size() > 0) begin
                    r = rq.pop_front();
                    if (!r.drop) mq.push_back('{pc: r.pc, code: imem_rdata, exc: 1'b0});
                end
                if (req && imem_gnt) begin
                    rq.push_back('{pc: m_pc, drop: 1'b0});
                    m_pc = m_pc + 32'd4;
                end else if (exc) begin
                    mq.push_back('{pc: m_pc, code: 32'h0, exc: 1'b1});
                    m_halt = 1;
                end
            end
        end
    end
    always @(negedge clk) begin
        if (started) begin
            chk("imem_req", imem_req, m_req());
            chk("imem_addr", imem_addr, m_pc);
            chk("pc_if", pc_if, m_pc);
            chk("occupancy", occupancy, mq.size());
            chk("id_valid", id_valid, mq.size() > 0);
            chk("id_pc", id_pc, mq.size() > 0 ? mq[0].pc : 32'h0);
            chk("id_code", id_code, mq.size() > 0 ? mq[0].code : 32'h0);
            chk("id_exc", id_exc, mq.size() > 0 ? mq[0].exc : 1'b0);
        end
    end
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask
    task automatic set(bit rs, bit rd, logic [31:0] rpc, bit g, bit rv, bit rdy);
        reset = rs;
        redirect = rd;
        redirect_pc = rpc;
        imem_gnt = g;
        imem_rvalid = rv && rq.size() > 0;
        imem_rdata = $urandom;
        id_ready = rdy;
    endtask
    task automatic drain(int n);
        for (int i = 0; i < n; i++) begin
            set(0, 0, 0, 0, 1, 1);
            nxt();
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal;
    end
    initial begin
        int grants;
        bit seen;
        logic [31:0] tg [6];
        tg = '{32'h3000, 32'h3100, 32'h3102, 32'h6ff0, 32'h2ffc, 32'hffff_fffc};
        set(1, 0, 0, 0, 0, 0);
        repeat (3) nxt();
        set(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_pc_if", pc_if, 32'h3000);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_imem_req", imem_req, 1);
        nxt();
        for (int k = 0; k < 8; k++) begin
            set(0, 0, 0, 1, 1, 1);
            @(negedge clk);
            chk("stream_addr", imem_addr, 32'h3000 + 32'(4 * k));
            chk("stream_occ_le1", occupancy <= 1, 1);
            nxt();
        end
        drain(4);
        grants = 0;
        for (int k = 0; k < 10; k++) begin
            set(0, 0, 0, 1, 1, 0);
            @(negedge clk);
            if (imem_req) grants++;
            nxt();
        end
        set(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("fill_grants", grants, 4);
        chk("fill_occ", occupancy, 4);
        chk("fill_req", imem_req, 0);
        nxt();
        set(0, 0, 0, 1, 0, 1);
        @(negedge clk);
        chk("release_occ0", occupancy, 4);
        chk("release_req0", imem_req, 0);
        nxt();
        set(0, 0, 0, 1, 0, 1);
        @(negedge clk);
        chk("release_occ1", occupancy, 3);
        chk("release_req1", imem_req, 1);
        nxt();
        drain(8);
        for (int k = 0; k < 3; k++) begin
            set(0, 0, 0, 1, 0, 1);
            nxt();
        end
        set(0, 1, 32'h3100, 1, 0, 1);
        @(negedge clk);
        chk("redir_no_req", imem_req, 0);
        nxt();
        set(0, 0, 0, 1, 1, 1);
        @(negedge clk);
        chk("redir_empty_valid", id_valid, 0);
        chk("redir_empty_occ", occupancy, 0);
        chk("redir_pc_if", pc_if, 32'h3100);
        nxt();
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            set(0, 0, 0, 1, 1, 1);
            @(negedge clk);
            if (id_valid) begin
                seen = 1;
                chk("redir_first_pc", id_pc, 32'h3100);
            end
            nxt();
        end
        if (!seen) chk("redir_first_timeout", 0, 1);
        set(0, 1, 32'h3102, 1, 1, 0);
        nxt();
        for (int k = 0; k < 8; k++) begin
            set(0, 0, 0, 1, 1, 0);
            @(negedge clk);
            chk("misalign_no_req", imem_req, 0);
            nxt();
        end
        set(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("misalign_occ", occupancy, 1);
        chk("misalign_pc", id_pc, 32'h3102);
        chk("misalign_exc", id_exc, 1);
        chk("misalign_code", id_code, 0);
        nxt();
        set(0, 1, 32'h3000, 1, 0, 0);
        nxt();
        set(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, 32'h3000);
        nxt();
        set(0, 1, 32'h6ff8, 1, 1, 0);
        nxt();
        for (int k = 0; k < 8; k++) begin
            set(0, 0, 0, 1, 1, 0);
            nxt();
        end
        set(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("end_occ", occupancy, 3);
        chk("end_pc_if", pc_if, 32'h7000);
        chk("end_req", imem_req, 0);
        chk("end_head", id_pc, 32'h6ff8);
        nxt();
        for (int k = 0; k < 2; k++) begin
            set(0, 0, 0, 1, 0, 1);
            nxt();
        end
        set(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("end_adel_pc", id_pc, 32'h7000);
        chk("end_adel_exc", id_exc, 1);
        nxt();
        set(0, 1, 32'h3000, 1, 0, 0);
        nxt();
        for (int k = 0; k < 3; k++) begin
            set(0, 0, 0, 1, k == 1, 0);
            nxt();
        end
        set(0, 1, 32'h3200, 1, 1, 1);
        @(negedge clk);
        chk("redir_pop_valid", id_valid, 1);
        nxt();
        set(0, 0, 0, 1, 1, 1);
        @(negedge clk);
        chk("redir_pop_occ", occupancy, 0);
        chk("redir_pop_valid_after", id_valid, 0);
        chk("redir_pop_pc_if", pc_if, 32'h3200);
        nxt();
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            set(0, 0, 0, 1, 1, 1);
            @(negedge clk);
            if (id_valid) begin
                seen = 1;
                chk("redir_pop_first_pc", id_pc, 32'h3200);
            end
            nxt();
        end
        if (!seen) chk("redir_pop_timeout", 0, 1);
        drain(8);
        for (int k = 0; k < 2; k++) begin
            set(0, 0, 0, 1, 0, 0);
            nxt();
        end
        for (int k = 0; k < 2; k++) begin
            set(1, 0, 0, 0, 1, 0);
            nxt();
        end
        for (int k = 0; k < 3; k++) begin
            set(0, 0, 0, 0, 0, 1);
            @(negedge clk);
            chk("post_rst_pc", pc_if, 32'h3000);
            chk("post_rst_valid", id_valid, 0);
            chk("post_rst_occ", occupancy, 0);
            nxt();
        end
        for (int k = 0; k < 3000; k++) begin
            reset = $urandom_range(0, 499) == 0;
            redirect = !reset && $urandom_range(0, 39) == 0;
            redirect_pc = tg[$urandom_range(0, 5)];
            imem_gnt = $urandom_range(0, 3) != 0;
            imem_rvalid = !reset && rq.size() > 0 && $urandom_range(0, 2) != 0;
            imem_rdata = $urandom;
            id_ready = $urandom_range(0, 3) != 0;
            nxt();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
